// File: rtl/prog_loader.sv
// Boot loader for the 4-bit CPU: takes a length/data/checksum nibble stream, writes
// assembled instruction words to memory, and releases the CPU only after a good checksum.
module prog_loader #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [3:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [3:0]        mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int NPW   = WORD_W / 4;
    localparam int NIB_W = (NPW > 1) ? $clog2(NPW) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]        state;
    logic [3:0]        acc;
    logic [3:0]        len_m1;
    logic [3:0]        word_idx;
    logic [NIB_W-1:0]  nib_idx;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_next;
    logic              xfer;

    always_comb begin
        xfer      = rx_valid && rx_ready;
        word_next = WORD_W'({shreg, rx_data});
    end

    // len_m1 holds N-1 so that N=0 (16 words) naturally ends on word index 15
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            acc       <= '0;
            len_m1    <= '0;
            word_idx  <= '0;
            nib_idx   <= '0;
            shreg     <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (load_start) begin
                        state     <= S_LEN;
                        rx_ready  <= 1'b1;
                        acc       <= '0;
                        word_idx  <= '0;
                        mem_addr  <= '0;
                        nib_idx   <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (xfer) begin
                        acc    <= rx_data;
                        len_m1 <= rx_data - 4'd1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
                        shreg <= word_next;
                        acc   <= acc + rx_data;
                        if (nib_idx == NIB_W'(NPW - 1)) begin
                            nib_idx   <= '0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx;
                            mem_wdata <= word_next;
                            word_idx  <= word_idx + 4'd1;
                            if (word_idx == len_m1) begin
                                state <= S_CHECK;
                            end
                        end else begin
                            nib_idx <= nib_idx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (rx_data == acc) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
